// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the conditional-branch predictor and recovery sequencer.
// Pure declarations, no logic and no latency.
// No flow control is involved.
package branch_predict_ctrl_pkg;

    // Post-conditional PC select: Branch_C means the branch was actually taken.
    typedef enum logic [1:0] {
        PCp4_I   = 2'd0,
        Branch_C = 2'd1,
        Jump_C   = 2'd2,
        Jump_R   = 2'd3
    } pcSrc;

    // Execute-stage branch kind; NO_BRANCH marks anything that is not a conditional branch.
    typedef enum logic [2:0] {
        NO_BRANCH = 3'd0,
        BEQ       = 3'd1,
        BNE       = 3'd2,
        BLT       = 3'd3,
        BGE       = 3'd4,
        BLTU      = 3'd5,
        BGEU      = 3'd6
    } conditionalPCSrc;

    // Recovery sequencer states.
    typedef enum logic {
        BP_IDLE     = 1'b0,
        BP_REDIRECT = 1'b1
    } bpState;

    // Every counter starts weakly not-taken.
    localparam logic [1:0] BHT_RESET = 2'b01;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Table of 2-bit saturating direction counters, one async read port, one sync write port.
// Read is combinational; write takes effect at the next clock edge (reads see pre-update data).
// No backpressure: a write request is always accepted.
module bht_counter_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr_q [ENTRIES];

    // Read straight from storage, so a same-cycle write is not bypassed.
    assign rd_ctr = ctr_q[rd_idx];

    // Reset every entry to weakly not-taken; otherwise train the written entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_RESET;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch direction predictor with misprediction redirect/flush sequencer and statistics.
// Prediction is combinational from PC_D; a redirect appears one cycle after the mispredicting resolve.
// Redirect is held (with a stable target) until fetch drops Stall_F; execute inputs are ignored meanwhile.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PC_D,
    input  logic            IsCondBranch_D,
    output logic            PredictTaken_D,
    input  conditionalPCSrc ConditionalPCSrc_E,
    input  pcSrc            PCSrcPostConditional_E,
    input  logic            PredictedTaken_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] BranchTarget_E,
    input  logic            Stall_E,
    input  logic            Stall_F,
    output logic            RedirectValid,
    output logic [XLEN-1:0] RedirectPC,
    output logic            Flush_D,
    output logic            Flush_E,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredictCount
);

    bpState state_q;
    bpState state_d;

    logic [1:0]          rd_ctr;
    logic                resolve;
    logic                actual_taken;
    logic                mispredict;
    logic [XLEN-1:0]     correct_pc;
    logic [XLEN-1:0]     redirect_pc_q;

    // Wrong-path execute contents during a redirect must never train or count.
    assign resolve      = (state_q == BP_IDLE) && !Stall_E && (ConditionalPCSrc_E != NO_BRANCH);
    assign actual_taken = (PCSrcPostConditional_E == Branch_C);
    assign mispredict   = resolve && (actual_taken != PredictedTaken_E);
    assign correct_pc   = actual_taken ? BranchTarget_E : (PC_E + XLEN'(4));

    bht_counter_table #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (PC_D[IDX_BITS+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (resolve),
        .wr_idx   (PC_E[IDX_BITS+1:2]),
        .wr_taken (actual_taken)
    );

    assign PredictTaken_D = IsCondBranch_D && rd_ctr[1];

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and redirect/flush outputs, decoded from the registered state.
    always_comb begin
        state_d       = state_q;
        RedirectValid = 1'b0;
        Flush_D       = 1'b0;
        Flush_E       = 1'b0;
        case (state_q)
            BP_IDLE: begin
                if (mispredict) state_d = BP_REDIRECT;
            end
            BP_REDIRECT: begin
                RedirectValid = 1'b1;
                Flush_D       = 1'b1;
                Flush_E       = 1'b1;
                if (!Stall_F) state_d = BP_IDLE;
            end
            default: state_d = BP_IDLE;
        endcase
    end

    // Capture the corrected fetch address only on a fresh mispredict; it is held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_pc_q <= '0;
        end else if (mispredict) begin
            redirect_pc_q <= correct_pc;
        end
    end

    assign RedirectPC = redirect_pc_q;

    // Statistics: both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (resolve)    BranchCount     <= BranchCount + 32'd1;
            if (mispredict) MispredictCount <= MispredictCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: table of per-cycle vectors with a scoreboard queue,
// followed by a hand-written reset-during-redirect sequence.
// Expected values are hand-derived constants in the table.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int IDX_BITS = 6;
    localparam int NVEC = 20;

    logic            clk;
    logic            reset_n;
    logic [XLEN-1:0] PC_D;
    logic            IsCondBranch_D;
    logic            PredictTaken_D;
    conditionalPCSrc ConditionalPCSrc_E;
    pcSrc            PCSrcPostConditional_E;
    logic            PredictedTaken_E;
    logic [XLEN-1:0] PC_E;
    logic [XLEN-1:0] BranchTarget_E;
    logic            Stall_E;
    logic            Stall_F;
    logic            RedirectValid;
    logic [XLEN-1:0] RedirectPC;
    logic            Flush_D;
    logic            Flush_E;
    logic [31:0]     BranchCount;
    logic [31:0]     MispredictCount;

    branch_predict_ctrl #(.XLEN(XLEN), .IDX_BITS(IDX_BITS)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .PC_D                   (PC_D),
        .IsCondBranch_D         (IsCondBranch_D),
        .PredictTaken_D         (PredictTaken_D),
        .ConditionalPCSrc_E     (ConditionalPCSrc_E),
        .PCSrcPostConditional_E (PCSrcPostConditional_E),
        .PredictedTaken_E       (PredictedTaken_E),
        .PC_E                   (PC_E),
        .BranchTarget_E         (BranchTarget_E),
        .Stall_E                (Stall_E),
        .Stall_F                (Stall_F),
        .RedirectValid          (RedirectValid),
        .RedirectPC             (RedirectPC),
        .Flush_D                (Flush_D),
        .Flush_E                (Flush_E),
        .BranchCount            (BranchCount),
        .MispredictCount        (MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall_e;
        logic        stall_f;
        logic        br;
        logic        tk;
        logic        pr;
        logic [31:0] pc_e;
        logic [31:0] tgt;
        logic [31:0] pc_d;
        logic        isc;
        logic        e_pt;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    typedef struct {
        int          id;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    vec_t vec [NVEC];
    exp_t sb_q [$];
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(input logic se, input logic sf, input logic br, input logic tk,
                                input logic pr, input logic [31:0] pce, input logic [31:0] tgt,
                                input logic [31:0] pcd, input logic isc, input logic ept,
                                input logic erv, input logic [31:0] erpc, input logic [31:0] ebc,
                                input logic [31:0] emc);
        vec_t v;
        v.stall_e = se;  v.stall_f = sf;  v.br = br;   v.tk = tk;   v.pr = pr;
        v.pc_e = pce;    v.tgt = tgt;     v.pc_d = pcd; v.isc = isc;
        v.e_pt = ept;    v.e_rv = erv;    v.e_rpc = erpc; v.e_bc = ebc; v.e_mc = emc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        Stall_E                = 1'b0;
        Stall_F                = 1'b0;
        ConditionalPCSrc_E     = NO_BRANCH;
        PCSrcPostConditional_E = PCp4_I;
        PredictedTaken_E       = 1'b0;
        PC_E                   = '0;
        BranchTarget_E         = '0;
        PC_D                   = '0;
        IsCondBranch_D         = 1'b0;
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_err = 0;

        //          se sf br tk pr pc_e          tgt           pc_d          isc pt rv rpc           bc  mc
        vec[0]  = mk(0, 0, 1, 1, 0, 32'h100,      32'h200,      32'h100,      1,  0, 1, 32'h200,      1,  1);
        vec[1]  = mk(0, 0, 1, 1, 0, 32'h100,      32'h999,      32'h100,      1,  1, 0, 32'h200,      1,  1);
        vec[2]  = mk(0, 0, 1, 1, 1, 32'h100,      32'h200,      32'h100,      1,  1, 0, 32'h200,      2,  1);
        vec[3]  = mk(0, 0, 1, 1, 1, 32'h100,      32'h200,      32'h100,      1,  1, 0, 32'h200,      3,  1);
        vec[4]  = mk(0, 0, 1, 1, 1, 32'h100,      32'h200,      32'h100,      1,  1, 0, 32'h200,      4,  1);
        vec[5]  = mk(0, 0, 0, 1, 0, 32'h100,      32'h700,      32'h100,      1,  1, 0, 32'h200,      4,  1);
        vec[6]  = mk(0, 0, 1, 0, 1, 32'hFFFFFFFC, 32'h1234,     32'h100,      0,  0, 1, 32'h0,        5,  2);
        vec[7]  = mk(0, 1, 1, 1, 0, 32'h100,      32'h888,      32'h100,      1,  1, 1, 32'h0,        5,  2);
        vec[8]  = mk(0, 1, 1, 0, 1, 32'h100,      32'h888,      32'h100,      1,  1, 1, 32'h0,        5,  2);
        vec[9]  = mk(0, 1, 1, 0, 1, 32'h100,      32'h888,      32'h100,      1,  1, 1, 32'h0,        5,  2);
        vec[10] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1,  1, 0, 32'h0,        5,  2);
        vec[11] = mk(0, 0, 1, 0, 0, 32'hFFFFFFFC, 32'h1234,     32'hFFFFFFFC, 1,  0, 0, 32'h0,        6,  2);
        vec[12] = mk(0, 0, 1, 0, 0, 32'hFFFFFFFC, 32'h1234,     32'hFFFFFFFC, 1,  0, 0, 32'h0,        7,  2);
        vec[13] = mk(0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h40,       32'hFFFFFFFC, 1,  0, 1, 32'h40,       8,  3);
        vec[14] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 1,  0, 0, 32'h40,       8,  3);
        vec[15] = mk(1, 0, 1, 1, 0, 32'h204,      32'h300,      32'h204,      1,  0, 0, 32'h40,       8,  3);
        vec[16] = mk(1, 0, 1, 1, 0, 32'h204,      32'h300,      32'h204,      1,  0, 0, 32'h40,       8,  3);
        vec[17] = mk(0, 0, 1, 1, 0, 32'h204,      32'h300,      32'h204,      1,  0, 1, 32'h300,      9,  4);
        vec[18] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h204,      1,  1, 0, 32'h300,      9,  4);
        vec[19] = mk(0, 0, 1, 1, 0, 32'h208,      32'h500,      32'h208,      1,  0, 1, 32'h500,      10, 5);

        // Reset state.
        drive_idle();
        reset_n = 1'b0;
        IsCondBranch_D = 1'b1;
        PC_D = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset RedirectValid", {31'd0, RedirectValid}, 32'd0);
        chk("reset Flush_D", {31'd0, Flush_D}, 32'd0);
        chk("reset Flush_E", {31'd0, Flush_E}, 32'd0);
        chk("reset RedirectPC", RedirectPC, 32'd0);
        chk("reset BranchCount", BranchCount, 32'd0);
        chk("reset MispredictCount", MispredictCount, 32'd0);
        chk("reset PredictTaken_D", {31'd0, PredictTaken_D}, 32'd0);
        reset_n = 1'b1;

        // Table-driven vectors, one per cycle, checked through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            Stall_E                = vec[i].stall_e;
            Stall_F                = vec[i].stall_f;
            ConditionalPCSrc_E     = vec[i].br ? BEQ : NO_BRANCH;
            PCSrcPostConditional_E = vec[i].tk ? Branch_C : PCp4_I;
            PredictedTaken_E       = vec[i].pr;
            PC_E                   = vec[i].pc_e;
            BranchTarget_E         = vec[i].tgt;
            PC_D                   = vec[i].pc_d;
            IsCondBranch_D         = vec[i].isc;
            #1;
            chk($sformatf("v%0d PredictTaken_D", i), {31'd0, PredictTaken_D}, {31'd0, vec[i].e_pt});
            e.id  = i;
            e.rv  = vec[i].e_rv;
            e.rpc = vec[i].e_rpc;
            e.bc  = vec[i].e_bc;
            e.mc  = vec[i].e_mc;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL v%0d scoreboard: queue empty, expected one entry", i);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d RedirectValid", e.id), {31'd0, RedirectValid}, {31'd0, e.rv});
                chk($sformatf("v%0d Flush_D", e.id), {31'd0, Flush_D}, {31'd0, e.rv});
                chk($sformatf("v%0d Flush_E", e.id), {31'd0, Flush_E}, {31'd0, e.rv});
                chk($sformatf("v%0d RedirectPC", e.id), RedirectPC, e.rpc);
                chk($sformatf("v%0d BranchCount", e.id), BranchCount, e.bc);
                chk($sformatf("v%0d MispredictCount", e.id), MispredictCount, e.mc);
            end
        end

        // Reset pulsed while the redirect from the last vector is pending.
        @(negedge clk);
        drive_idle();
        Stall_F = 1'b1;
        #1;
        chk("pre-pulse RedirectValid", {31'd0, RedirectValid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("pulse RedirectValid", {31'd0, RedirectValid}, 32'd0);
        chk("pulse Flush_D", {31'd0, Flush_D}, 32'd0);
        chk("pulse RedirectPC", RedirectPC, 32'd0);
        chk("pulse BranchCount", BranchCount, 32'd0);
        chk("pulse MispredictCount", MispredictCount, 32'd0);
        IsCondBranch_D = 1'b1;
        for (int k = 0; k < (1 << IDX_BITS); k++) begin
            PC_D = 32'(k) << 2;
            #1;
            chk($sformatf("pulse PredictTaken_D idx %0d", k), {31'd0, PredictTaken_D}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-pulse RedirectValid", {31'd0, RedirectValid}, 32'd0);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Per-PC conditional-branch direction predictor plus misprediction recovery sequencer.
- Decode reads a 2-bit counter table (BHT) to steer fetch.
- Execute resolves the branch through the post-conditional PC select. On disagreement with the carried prediction, the block issues a registered redirect, flushes Decode/Execute, and holds the redirect until fetch accepts it.
- Also keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_BITS, 6, BHT index width; 2^IDX_BITS entries, indexed by PC[IDX_BITS+1:2].

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- PC_D  in  XLEN  decode-stage PC.
- IsCondBranch_D  in  1  decode instruction is conditional branch.
- PredictTaken_D  out  1  BHT prediction, combinational from PC_D; 0 when IsCondBranch_D=0.
- ConditionalPCSrc_E  in  conditionalPCSrc  execute branch kind; NO_BRANCH = not a conditional branch.
- PCSrcPostConditional_E  in  pcSrc  resolved select; Branch_C = taken.
- PredictedTaken_E  in  1  prediction carried down the pipe with the instruction.
- PC_E  in  XLEN  execute-stage PC.
- BranchTarget_E  in  XLEN  computed taken target.
- Stall_E  in  1  execute stage held; no resolution this cycle.
- Stall_F  in  1  fetch cannot accept redirect this cycle.
- RedirectValid  out  1  fetch must load RedirectPC.
- RedirectPC  out  XLEN  corrected fetch address.
- Flush_D  out  1  squash decode register.
- Flush_E  out  1  squash execute register.
- BranchCount  out  32  conditional branches resolved.
- MispredictCount  out  32  mispredictions.

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE; RedirectValid, Flush_D, Flush_E = 0; RedirectPC = 0.
  - Both counters = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
- Resolve event:
  - Occurs when state==IDLE, Stall_E=0 and ConditionalPCSrc_E != NO_BRANCH.
  - Actual = (PCSrcPostConditional_E == Branch_C).
  - Mispredict = Actual != PredictedTaken_E.
- BHT:
  - Prediction = counter[1].
  - On resolve, the entry at PC_E[IDX_BITS+1:2] saturating-increments if Actual, else saturating-decrements. 11 stays 11 when taken; 00 stays 00 when not taken.
  - Same-cycle read/write of the same index: the read returns the pre-update value (no bypass).
- Counters: BranchCount +1 per resolve; MispredictCount +1 per mispredict; both wrap modulo 2^32.
- FSM states: IDLE, REDIRECT.
  - IDLE -> REDIRECT on mispredict (registered). RedirectPC latched = Actual ? BranchTarget_E : PC_E+4, with XLEN-bit truncating add.
  - REDIRECT outputs: RedirectValid=1, Flush_D=1, Flush_E=1.
  - REDIRECT -> IDLE when Stall_F=0. If Stall_F=1, stay in REDIRECT with all outputs and RedirectPC held stable.
- Latency: mispredict resolved in cycle N -> redirect/flush visible in cycle N+1 (minimum one cycle).
- While in REDIRECT:
  - Execute inputs are wrong-path and fully ignored: no BHT update, no counting, no new redirect.
- Other boundary rules:
  - Stall_E=1 with a branch in E: nothing happens until released; exactly one update per branch.
  - Correct prediction: BHT update and count only; no flush.
  - Non-conditional jumps (NO_BRANCH) are never touched.
  - reset_n asserted mid-REDIRECT: immediate return to IDLE, redirect dropped.

Decomposition:
- Add to HighLevelControl package:
  - bpState enum {BP_IDLE, BP_REDIRECT}.
  - Constant BHT_RESET = 2'b01.
- Existing pcSrc/conditionalPCSrc types are reused unchanged.
- One sub-module: bht_counter_table (parameterised 2-bit saturating table, one async read port, one sync write port, async reset).

Test Plan:
- Reset, then BEQ at PC 0x100, PredictedTaken_E=0, PCSrcPostConditional_E=Branch_C, target 0x200 -> next cycle RedirectValid=1, RedirectPC=0x200, Flush_D=Flush_E=1; entry 0 goes 01->10; MispredictCount=1.
- Same PC again in decode -> PredictTaken_D=1. Resolve taken with PredictedTaken_E=1 -> no redirect, entry 10->11; BranchCount=2, MispredictCount unchanged.
- Predicted taken, resolves PCp4_I at PC_E=0xFFFFFFFC -> RedirectPC=0x00000000 (wrap).
- Mispredict with Stall_F=1 for 3 cycles -> RedirectValid held 4 cycles, RedirectPC constant. Branch presented on E during hold -> no count, no BHT change.
- Saturation: entry at 11 resolved taken twice -> stays 11. Entry driven to 00 and resolved not-taken -> stays 00.
- Branch in E with Stall_E=1 for 2 cycles, then released -> BranchCount +1 exactly once. Separately, reset_n pulsed low during REDIRECT -> RedirectValid=0 immediately, counters 0, PredictTaken_D=0 for all PCs.
